vproc_cfg_unit: RTL and testbench

//  Parametrised vector-configuration unit: executes vsetvl/vsetvli/vsetivli requests and holds the live vtype/vl state.

---
 rtl/vproc_pkg.sv | 52 +++++
 rtl/vproc_cfg_vlmax.sv | 75 +++++++
 rtl/vproc_cfg_unit.sv | 200 ++++++++++++++++++++
 tb/tb_vproc_cfg_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
// ---------------------------------------------------------------------------
// vproc_pkg
// Shared types for the vector configuration unit.
//   cfg_vsew    : selected element width encoding (vtype.vsew)
//   cfg_lmul    : register group multiplier encoding (vtype.vlmul)
//   op_mode_cfg : decoded vsetvl* request mode
//   cfg_state_e : configuration unit FSM states
// Optional build macro: VPROC_CFG_SEW64_EN enables the 64-bit SEW encoding.
// ---------------------------------------------------------------------------
package vproc_pkg;

    localparam int unsigned CFG_XLEN    = 32;  // width of AVL and of the rd result
    localparam int unsigned CFG_SEW_MIN = 8;   // narrowest element width in bits

    typedef enum logic [1:0] {
        VSEW_8       = 2'b00,
        VSEW_16      = 2'b01,
        VSEW_32      = 2'b10,
`ifdef VPROC_CFG_SEW64_EN
        VSEW_64      = 2'b11
`else
        VSEW_INVALID = 2'b11
`endif
    } cfg_vsew;

    typedef enum logic [2:0] {
        LMUL_1       = 3'b000,
        LMUL_2       = 3'b001,
        LMUL_4       = 3'b010,
        LMUL_8       = 3'b011,
        LMUL_INVALID = 3'b100,
        LMUL_F8      = 3'b101,
        LMUL_F4      = 3'b110,
        LMUL_F2      = 3'b111
    } cfg_lmul;

    typedef struct packed {
        cfg_vsew    vsew;
        cfg_lmul    lmul;
        logic [1:0] agnostic;  // {vma, vta}
        logic       vlmax;     // rs1 == x0, rd != x0: request vl = VLMAX
        logic       keep_vl;   // rs1 == x0, rd == x0: keep current vl
    } op_mode_cfg;

    typedef enum logic [1:0] {
        CFG_IDLE,
        CFG_DRAIN,
        CFG_CALC,
        CFG_RESP
    } cfg_state_e;

endpackage

// File: rtl/vproc_cfg_vlmax.sv
// ---------------------------------------------------------------------------
// vproc_cfg_vlmax
// Combinational VLMAX and legality evaluation for one (vsew, lmul) pair.
//   i_vsew  : requested element width
//   i_lmul  : requested register group multiplier
//   o_vlmax : elements per register group, (VREG_W/SEW) * LMUL
//   o_vill  : requested vtype cannot be configured
// Optional build macro: VPROC_CFG_SEW64_EN (accepts the 64-bit SEW encoding).
// ---------------------------------------------------------------------------
module vproc_cfg_vlmax
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W   = 128,
    parameter int unsigned ELEN     = 32,
    parameter int unsigned CFG_VL_W = $clog2(VREG_W) + 1
) (
    input  cfg_vsew             i_vsew,
    input  cfg_lmul             i_lmul,
    output logic [CFG_VL_W-1:0] o_vlmax,
    output logic                o_vill
);

    localparam logic [CFG_VL_W-1:0] ELEMS_SEW8 = CFG_VL_W'(VREG_W / 8);

    logic [1:0]          w_sew_log;   // log2(SEW / 8)
    logic [2:0]          w_frac_log;  // log2 of the LMUL denominator, 0 for integer LMUL
    logic [CFG_VL_W-1:0] w_per_reg;
    logic                w_sew_bad;
    logic                w_lmul_bad;
    logic                w_frac_bad;

    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // through the case statements can leave a value held, which would infer a latch.
        w_sew_log  = 2'd0;
        w_sew_bad  = 1'b0;
        w_frac_log = 3'd0;
        w_lmul_bad = 1'b0;
        o_vlmax    = '0;

        case (i_vsew)
            VSEW_8:  w_sew_log = 2'd0;
            VSEW_16: w_sew_log = 2'd1;
            VSEW_32: w_sew_log = 2'd2;
`ifdef VPROC_CFG_SEW64_EN
            VSEW_64: w_sew_log = 2'd3;
`endif
            default: w_sew_bad = 1'b1;
        endcase
        // An element wider than ELEN is never legal, whatever the encoding.
        if ((CFG_SEW_MIN << w_sew_log) > ELEN) begin
            w_sew_bad = 1'b1;
        end

        w_per_reg = ELEMS_SEW8 >> w_sew_log;

        case (i_lmul)
            LMUL_1:  o_vlmax = w_per_reg;
            LMUL_2:  o_vlmax = w_per_reg << 1;
            LMUL_4:  o_vlmax = w_per_reg << 2;
            LMUL_8:  o_vlmax = w_per_reg << 3;
            LMUL_F2: begin o_vlmax = w_per_reg >> 1; w_frac_log = 3'd1; end
            LMUL_F4: begin o_vlmax = w_per_reg >> 2; w_frac_log = 3'd2; end
            LMUL_F8: begin o_vlmax = w_per_reg >> 3; w_frac_log = 3'd3; end
            default: w_lmul_bad = 1'b1;
        endcase

        // A fractional group must still hold one narrowest element at the
        // widest supported element width, i.e. LMUL >= SEW_MIN / ELEN.
        w_frac_bad = (ELEN >> w_frac_log) < CFG_SEW_MIN;

        o_vill = w_sew_bad | w_lmul_bad | w_frac_bad | (o_vlmax == '0);
    end

endmodule

// File: rtl/vproc_cfg_unit.sv
// ---------------------------------------------------------------------------
// vproc_cfg_unit
// Executes vsetvl/vsetvli/vsetivli and holds the live vtype/vl state.
// In-flight vector instructions are drained before a new configuration commits.
//   clk_i, sync_rst_ni            : clock, synchronous active-low reset
//   req_valid_i/req_ready_o       : config request handshake
//   req_avl_i, req_mode_i         : AVL and decoded request mode
//   resp_valid_o/resp_ready_i     : result handshake, resp_vl_o is the new vl
//   issue_valid_i/issue_ready_o   : dispatch of one instruction under current config
//   retire_i                      : completion of one in-flight instruction
//   vsew_o, lmul_o, agnostic_o,
//   vl_o, vl_0_o, vill_o          : live configuration for the execution units
// Optional build macro: VPROC_CFG_SEW64_EN (64-bit SEW, needs ELEN = 64).
// ---------------------------------------------------------------------------
module vproc_cfg_unit
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W       = 128,
    parameter int unsigned ELEN         = 32,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned CFG_VL_W     = $clog2(VREG_W) + 1
) (
    input  logic                clk_i,
    input  logic                sync_rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_avl_i,
    input  op_mode_cfg          req_mode_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [31:0]         resp_vl_o,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic                retire_i,
    output cfg_vsew             vsew_o,
    output cfg_lmul             lmul_o,
    output logic [1:0]          agnostic_o,
    output logic [CFG_VL_W-1:0] vl_o,
    output logic                vl_0_o,
    output logic                vill_o
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    cfg_state_e          r_state;
    cfg_state_e          w_state_next;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic                w_inc;
    logic                w_dec;

    logic [31:0]         r_avl;
    op_mode_cfg          r_mode;

    cfg_vsew             r_vsew;
    cfg_lmul             r_lmul;
    logic [1:0]          r_agnostic;
    logic [CFG_VL_W-1:0] r_vl;
    logic                r_vill;
    logic [31:0]         r_resp_vl;

    logic [CFG_VL_W-1:0] w_vlmax;
    logic                w_vlmax_vill;
    logic                w_keep_bad;
    logic                w_vill_new;
    logic [CFG_VL_W-1:0] w_vl_new;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!sync_rst_ni) begin
            r_state <= CFG_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        req_ready_o   = 1'b0;
        issue_ready_o = 1'b0;
        resp_valid_o  = 1'b0;
        case (r_state)
            CFG_IDLE: begin
                req_ready_o   = 1'b1;
                issue_ready_o = r_count < CNT_W'(MAX_INFLIGHT);
                if (req_valid_i) begin
                    w_state_next = CFG_DRAIN;
                end
            end
            // Registered count: a retire that empties the unit is seen one cycle later.
            CFG_DRAIN: begin
                if (r_count == '0) begin
                    w_state_next = CFG_CALC;
                end
            end
            CFG_CALC: w_state_next = CFG_RESP;
            CFG_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    w_state_next = CFG_IDLE;
                end
            end
            default: w_state_next = CFG_IDLE;
        endcase
    end

    // ---------------- in-flight counter ----------------
    assign w_inc = issue_valid_i && issue_ready_o;
    assign w_dec = retire_i && (r_count != '0);  // retire at zero is dropped

    always_comb begin
        w_count_next = r_count;
        if (w_inc && !w_dec) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_inc && w_dec) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // ---------------- request latch ----------------
    // NOTE: the AVL/mode latch is deliberately not reset; it is only read in
    // CALC, which is reachable solely after a handshake has loaded it.
    always_ff @(posedge clk_i) begin
        if (r_state == CFG_IDLE && req_valid_i) begin
            r_avl  <= req_avl_i;
            r_mode <= req_mode_i;
        end
    end

    // ---------------- new configuration ----------------
    vproc_cfg_vlmax #(
        .VREG_W   (VREG_W),
        .ELEN     (ELEN),
        .CFG_VL_W (CFG_VL_W)
    ) u_vlmax (
        .i_vsew  (r_mode.vsew),
        .i_lmul  (r_mode.lmul),
        .o_vlmax (w_vlmax),
        .o_vill  (w_vlmax_vill)
    );

    always_comb begin
        // keep_vl is only legal when the current vl still fits the new group.
        w_keep_bad = r_mode.keep_vl && !r_mode.vlmax && (r_vl > w_vlmax);
        w_vill_new = w_vlmax_vill || w_keep_bad;
        if (w_vill_new) begin
            w_vl_new = '0;
        end else if (r_mode.vlmax) begin
            w_vl_new = w_vlmax;
        end else if (r_mode.keep_vl) begin
            w_vl_new = r_vl;
        end else if (r_avl < CFG_XLEN'(w_vlmax)) begin
            w_vl_new = r_avl[CFG_VL_W-1:0];  // fits: AVL < VLMAX <= VREG_W
        end else begin
            w_vl_new = w_vlmax;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_vsew     <= VSEW_8;
            r_lmul     <= LMUL_1;
            r_agnostic <= 2'b00;
            r_vl       <= '0;
            r_vill     <= 1'b1;
            r_resp_vl  <= '0;
        end else if (r_state == CFG_CALC) begin
            r_vsew     <= w_vill_new ? VSEW_8 : r_mode.vsew;
            r_lmul     <= w_vill_new ? LMUL_1 : r_mode.lmul;
            r_agnostic <= r_mode.agnostic;
            r_vl       <= w_vl_new;
            r_vill     <= w_vill_new;
            r_resp_vl  <= CFG_XLEN'(w_vl_new);
        end
    end

    assign vsew_o     = r_vsew;
    assign lmul_o     = r_lmul;
    assign agnostic_o = r_agnostic;
    assign vl_o       = r_vl;
    assign vl_0_o     = (r_vl == '0);
    assign vill_o     = r_vill;
    assign resp_vl_o  = r_resp_vl;

    // A retire with nothing in flight means upstream bookkeeping is broken.
    a_no_retire_underflow: assert property (
        @(posedge clk_i) disable iff (!sync_rst_ni) !(retire_i && (r_count == '0))
    );

endmodule

// File: tb/tb_vproc_cfg_unit.sv
// ---------------------------------------------------------------------------
// tb_vproc_cfg_unit
// Self-checking bench for vproc_cfg_unit (VREG_W=128, MAX_INFLIGHT=8).
// Expected rd results are queued when a request is accepted and compared
// when the DUT completes the response handshake.
// Optional build macro: VPROC_CFG_SEW64_EN (bench then uses ELEN=64).
// ---------------------------------------------------------------------------
module tb_vproc_cfg_unit;
    import vproc_pkg::*;

`ifdef VPROC_CFG_SEW64_EN
    localparam int unsigned ELEN_P = 64;
`else
    localparam int unsigned ELEN_P = 32;
`endif
    localparam int unsigned VREG_W_P = 128;
    localparam int unsigned MAX_INF  = 8;
    localparam int unsigned VL_W     = $clog2(VREG_W_P) + 1;

    logic            clk = 1'b0;
    logic            sync_rst_ni;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [31:0]     req_avl_i;
    op_mode_cfg      req_mode_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [31:0]     resp_vl_o;
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic            retire_i;
    cfg_vsew         vsew_o;
    cfg_lmul         lmul_o;
    logic [1:0]      agnostic_o;
    logic [VL_W-1:0] vl_o;
    logic            vl_0_o;
    logic            vill_o;

    always #5 clk = ~clk;

    vproc_cfg_unit #(
        .VREG_W       (VREG_W_P),
        .ELEN         (ELEN_P),
        .MAX_INFLIGHT (MAX_INF)
    ) dut (
        .clk_i         (clk),
        .sync_rst_ni   (sync_rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_avl_i     (req_avl_i),
        .req_mode_i    (req_mode_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_vl_o     (resp_vl_o),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .retire_i      (retire_i),
        .vsew_o        (vsew_o),
        .lmul_o        (lmul_o),
        .agnostic_o    (agnostic_o),
        .vl_o          (vl_o),
        .vl_0_o        (vl_0_o),
        .vill_o        (vill_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: compare rd result on each completed response handshake.
    always @(negedge clk) begin
        if (sync_rst_ni && resp_valid_o && resp_ready_i) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid_o), 32'd0);
            end else begin
                check("resp_vl", resp_vl_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic op_mode_cfg mk(input logic [1:0] sew, input logic [2:0] lmul,
                                      input logic [1:0] agn, input logic vlmax, input logic keep);
        op_mode_cfg m;
        m.vsew     = cfg_vsew'(sew);
        m.lmul     = cfg_lmul'(lmul);
        m.agnostic = agn;
        m.vlmax    = vlmax;
        m.keep_vl  = keep;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for acceptance, queue the expected result.
    task automatic send_cfg(input logic [31:0] avl, input op_mode_cfg mode, input int unsigned exp_vl);
        int n = 0;
        req_valid_i = 1'b1;
        req_avl_i   = avl;
        req_mode_i  = mode;
        while (!req_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!req_ready_o) begin
            check("req_timeout", 32'(req_ready_o), 32'd1);
        end else begin
            exp_q.push_back(exp_vl);
        end
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid_o && lat < 100) begin
            tick();
            lat++;
        end
        if (!resp_valid_o) begin
            check("resp_timeout", 32'(resp_valid_o), 32'd1);
        end
    endtask

    // Full transaction from an idle unit with no instructions in flight.
    task automatic run_cfg(input string tag, input logic [31:0] avl, input op_mode_cfg mode,
                           input int unsigned exp_vl, input logic exp_vill);
        int lat;
        send_cfg(avl, mode, exp_vl);
        wait_resp(lat);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_vl"}, 32'(vl_o), exp_vl);
        check({tag, "_vill"}, 32'(vill_o), 32'(exp_vill));
        check({tag, "_vl0"}, 32'(vl_0_o), 32'(exp_vl == 0));
        tick();
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            issue_valid_i = 1'b1;
            check("issue_ready", 32'(issue_ready_o), 32'd1);
            tick();
        end
        issue_valid_i = 1'b0;
    endtask

    task automatic retire_one();
        retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
    endtask

    initial begin
        int lat;
        sync_rst_ni   = 1'b0;
        req_valid_i   = 1'b0;
        req_avl_i     = '0;
        req_mode_i    = mk(2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
        resp_ready_i  = 1'b1;
        issue_valid_i = 1'b0;
        retire_i      = 1'b0;
        repeat (3) tick();
        sync_rst_ni = 1'b1;

        // Reset state
        check("rst_vill", 32'(vill_o), 32'd1);
        check("rst_vl", 32'(vl_o), 32'd0);
        check("rst_vl0", 32'(vl_0_o), 32'd1);
        check("rst_vsew", 32'(vsew_o), 32'(VSEW_8));
        check("rst_lmul", 32'(lmul_o), 32'(LMUL_1));
        check("rst_agn", 32'(agnostic_o), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        check("rst_issue_ready", 32'(issue_ready_o), 32'd1);

        // Basic configurations
        run_cfg("sew8_m1", 32'd100, mk(VSEW_8, LMUL_1, 2'b10, 1'b0, 1'b0), 16, 1'b0);
        check("sew8_m1_agn", 32'(agnostic_o), 32'd2);
        run_cfg("sew32_f2", 32'd3, mk(VSEW_32, LMUL_F2, 2'b00, 1'b0, 1'b0), 2, 1'b0);
        check("sew32_f2_vsew", 32'(vsew_o), 32'(VSEW_32));
        check("sew32_f2_lmul", 32'(lmul_o), 32'(LMUL_F2));
        run_cfg("sew32_f8", 32'd5, mk(VSEW_32, LMUL_F8, 2'b00, 1'b0, 1'b0), 0, 1'b1);
        check("sew32_f8_vsew", 32'(vsew_o), 32'(VSEW_8));
        check("sew32_f8_lmul", 32'(lmul_o), 32'(LMUL_1));

        // keep_vl
        run_cfg("keep_base", 32'd100, mk(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 16, 1'b0);
        run_cfg("keep_bad", 32'd0, mk(VSEW_16, LMUL_1, 2'b00, 1'b0, 1'b1), 0, 1'b1);
        run_cfg("keep_base2", 32'd100, mk(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 16, 1'b0);
        run_cfg("keep_ok", 32'd0, mk(VSEW_8, LMUL_2, 2'b00, 1'b0, 1'b1), 16, 1'b0);
        check("keep_ok_lmul", 32'(lmul_o), 32'(LMUL_2));

        // vlmax request, wide AVL, zero AVL, reserved LMUL, SEW encoding 2'b11
        run_cfg("vlmax_flag", 32'd0, mk(VSEW_16, LMUL_4, 2'b00, 1'b1, 1'b0), 32, 1'b0);
        run_cfg("avl_wide", 32'h0001_0005, mk(VSEW_8, LMUL_8, 2'b00, 1'b0, 1'b0), 128, 1'b0);
        run_cfg("avl_zero", 32'd0, mk(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 0, 1'b0);
        run_cfg("lmul_rsv", 32'd10, mk(VSEW_8, LMUL_INVALID, 2'b00, 1'b0, 1'b0), 0, 1'b1);
`ifdef VPROC_CFG_SEW64_EN
        run_cfg("sew64_m8", 32'd99, mk(2'b11, LMUL_8, 2'b00, 1'b0, 1'b0), 16, 1'b0);
`else
        run_cfg("sew_rsv", 32'd99, mk(2'b11, LMUL_8, 2'b00, 1'b0, 1'b0), 0, 1'b1);
`endif

        // Drain: three in flight, request waits for the third retire
        run_cfg("drain_pre", 32'd9, mk(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 9, 1'b0);
        issue_n(3);
        send_cfg(32'd100, mk(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 16);
        issue_valid_i = 1'b1;
        repeat (3) begin
            check("drain_no_resp", 32'(resp_valid_o), 32'd0);
            check("drain_issue_ready", 32'(issue_ready_o), 32'd0);
            check("drain_req_ready", 32'(req_ready_o), 32'd0);
            check("drain_vl_stable", 32'(vl_o), 32'd9);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            retire_one();
            if (i < 2) begin
                tick();
                check("drain_wait", 32'(resp_valid_o), 32'd0);
            end
        end
        issue_valid_i = 1'b0;
        wait_resp(lat);
        check("drain_lat", 32'(lat), 32'd2);
        check("drain_vl", 32'(vl_o), 32'd16);
        tick();

        // Counter saturation and simultaneous issue+retire at the limit
        issue_n(MAX_INF);
        check("full_issue_ready", 32'(issue_ready_o), 32'd0);
        issue_valid_i = 1'b1;
        retire_i      = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        retire_i      = 1'b0;
        check("simul_to_7", 32'(issue_ready_o), 32'd1);
        issue_n(1);
        check("refill_to_8", 32'(issue_ready_o), 32'd0);
        repeat (MAX_INF) retire_one();
        run_cfg("after_full", 32'd4, mk(VSEW_16, LMUL_1, 2'b00, 1'b0, 1'b0), 4, 1'b0);

        // Reset while a response is pending
        resp_ready_i = 1'b0;
        send_cfg(32'd7, mk(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 7);
        wait_resp(lat);
        tick();
        tick();
        check("hold_valid", 32'(resp_valid_o), 32'd1);
        check("hold_vl", resp_vl_o, 32'd7);
        sync_rst_ni = 1'b0;
        tick();
        sync_rst_ni = 1'b1;
        check("rst2_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst2_vill", 32'(vill_o), 32'd1);
        check("rst2_vl", 32'(vl_o), 32'd0);
        check("rst2_req_ready", 32'(req_ready_o), 32'd1);
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        resp_ready_i = 1'b1;
        run_cfg("post_rst", 32'd20, mk(VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 16, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
